// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one comparator among N_REQ requesters.
// Registered grant, issue handshake, flag capture and a hung-comparator watchdog.
module cmp_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   gt_out,
    output logic                   eq_out,
    output logic                   err,
    output logic                   cmp_cs,
    output logic [WIDTH-1:0]       cmp_a,
    output logic [WIDTH-1:0]       cmp_b,
    input  logic                   cmp_ready,
    input  logic                   cmp_cout,
    input  logic                   cmp_zflag
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WBUSY = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] winner;
    logic [TW-1:0]   timer;
    logic [IDXW-1:0] pick;
    logic            any_req;
    logic            expired;

    function automatic logic [IDXW-1:0] rr_idx(
        input logic [IDXW-1:0] base,
        input int              k
    );
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IDXW'(s);
    endfunction

    // Scan downward so the lowest offset from ptr is the last, winning, hit.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[rr_idx(ptr, k)]) begin
                pick    = rr_idx(ptr, k);
                any_req = 1'b1;
            end
        end
    end

    // Timer may pass TIMEOUT-1 by one when WAIT_BUSY exits on its last cycle.
    assign expired = (timer >= TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= '0;
            winner <= '0;
            timer  <= '0;
            gnt    <= '0;
            done   <= '0;
            gt_out <= 1'b0;
            eq_out <= 1'b0;
            err    <= 1'b0;
            cmp_cs <= 1'b0;
            cmp_a  <= '0;
            cmp_b  <= '0;
        end else begin
            done   <= '0;
            cmp_cs <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        winner <= pick;
                        gnt    <= N_REQ'(1) << pick;
                        cmp_a  <= a_in[pick*WIDTH +: WIDTH];
                        cmp_b  <= b_in[pick*WIDTH +: WIDTH];
                        // An idle comparator stays idle until we select it.
                        cmp_cs <= cmp_ready;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmp_cs) begin
                        timer <= '0;
                        state <= S_WBUSY;
                    end else begin
                        cmp_cs <= cmp_ready;
                    end
                end
                S_WBUSY: begin
                    if (!cmp_ready) begin
                        timer <= timer + 1'b1;
                        state <= S_WDONE;
                    end else if (expired) begin
                        gt_out <= 1'b0;
                        eq_out <= 1'b0;
                        err    <= 1'b1;
                        done   <= gnt;
                        state  <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WDONE: begin
                    if (cmp_ready) begin
                        gt_out <= cmp_cout;
                        eq_out <= cmp_zflag;
                        err    <= 1'b0;
                        done   <= gnt;
                        state  <= S_RESP;
                    end else if (expired) begin
                        gt_out <= 1'b0;
                        eq_out <= 1'b0;
                        err    <= 1'b1;
                        done   <= gnt;
                        state  <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (winner == IDXW'(N_REQ - 1)) ptr <= '0;
                    else ptr <= winner + 1'b1;
                    gnt    <= '0;
                    gt_out <= 1'b0;
                    eq_out <= 1'b0;
                    err    <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed vectors with a queue scoreboard and a done monitor.
// A small comparator model answers cmp_cs with two busy cycles.
module tb_cmp_arbiter;

    localparam int TO = 16;

    typedef struct {
        logic [1:0] mask;
        logic       gt;
        logic       eq;
        logic       er;
        int         lat;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        gt_out;
    logic        eq_out;
    logic        err;
    logic        cmp_cs;
    logic [7:0]  cmp_a;
    logic [7:0]  cmp_b;
    logic        cmp_ready;
    logic        cmp_cout = 1'b0;
    logic        cmp_zflag = 1'b0;

    logic force_low = 1'b0;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cs_cnt = 0;
    int   cs_cyc = 0;
    int   last_done = 0;
    exp_t sbq[$];

    cmp_arbiter #(
        .N_REQ(2),
        .WIDTH(8),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .a_in(a_in),
        .b_in(b_in),
        .gnt(gnt),
        .done(done),
        .gt_out(gt_out),
        .eq_out(eq_out),
        .err(err),
        .cmp_cs(cmp_cs),
        .cmp_a(cmp_a),
        .cmp_b(cmp_b),
        .cmp_ready(cmp_ready),
        .cmp_cout(cmp_cout),
        .cmp_zflag(cmp_zflag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator model: busy for two cycles after an accepted select.
    always @(posedge clk) begin
        if (cmp_cs && cmp_ready) begin
            busy_cnt  <= 2;
            cmp_cout  <= (cmp_a > cmp_b);
            cmp_zflag <= (cmp_a == cmp_b);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign cmp_ready = (busy_cnt == 0) && !force_low;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cs_cnt = 0;
        end else begin
            if (cmp_cs) begin
                cs_cnt++;
                cs_cyc = cyc;
                chk("cs_ready", int'(cmp_ready), 1);
            end
            if (done != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_mask", int'(done), int'(e.mask));
                    chk("gnt_at_done", int'(gnt), int'(e.mask));
                    chk("gt_out", int'(gt_out), int'(e.gt));
                    chk("eq_out", int'(eq_out), int'(e.eq));
                    chk("err", int'(err), int'(e.er));
                    chk("cs_pulses", cs_cnt, 1);
                    if (e.lat >= 0) chk("latency", cyc - cs_cyc, e.lat);
                    if (e.gap >= 0) chk("done_gap", cyc - last_done, e.gap);
                end
                last_done = cyc;
                cs_cnt = 0;
            end
        end
    end

    task automatic push(
        input logic [1:0] m, input logic g, input logic q,
        input logic r, input int lat, input int gap
    );
        exp_t e;
        e.mask = m;
        e.gt   = g;
        e.eq   = q;
        e.er   = r;
        e.lat  = lat;
        e.gap  = gap;
        sbq.push_back(e);
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*8 +: 8] = a;
        b_in[i*8 +: 8] = b;
        req[i] = 1'b1;
    endtask

    task automatic wait_done(input int i, input int limit);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_done", int'(seen), 1);
        req[i] = 1'b0;
    endtask

    task automatic wait_cs(input int limit);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (cmp_cs) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_cs", int'(seen), 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_gnt"}, int'(gnt), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_flags"}, int'({gt_out, eq_out, err}), 0);
        chk({name, "_cs"}, int'(cmp_cs), 0);
        chk({name, "_ab"}, int'({cmp_a, cmp_b}), 0);
    endtask

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: greater-than; operand change after grant must be ignored
        issue(0, 8'h25, 8'h10);
        push(2'b01, 1'b1, 1'b0, 1'b0, 4, -1);
        @(negedge clk);
        chk("t1_gnt", int'(gnt), 1);
        a_in[7:0] = 8'h00;
        wait_done(0, 20);
        @(negedge clk);

        // T2: equal, then less-than with req dropped mid-operation
        issue(1, 8'h3C, 8'h3C);
        push(2'b10, 1'b0, 1'b1, 1'b0, 4, -1);
        wait_done(1, 20);
        @(negedge clk);
        issue(1, 8'h01, 8'hFF);
        push(2'b10, 1'b0, 1'b0, 1'b0, 4, -1);
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        wait_done(1, 20);
        @(negedge clk);

        // T3: both held, alternating grants, done every 6 cycles
        push(2'b01, 1'b1, 1'b0, 1'b0, 4, -1);
        push(2'b10, 1'b0, 1'b0, 1'b0, 4, 6);
        push(2'b01, 1'b1, 1'b0, 1'b0, 4, 6);
        push(2'b10, 1'b0, 1'b0, 1'b0, 4, 6);
        issue(0, 8'h80, 8'h7F);
        issue(1, 8'h05, 8'h06);
        nd = 0;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            @(negedge clk);
            if (done != 2'b00) nd++;
        end
        chk("t3_ops", nd, 4);
        req = 2'b00;
        @(negedge clk);

        // T4: comparator hangs busy; watchdog aborts with err
        issue(0, 8'h40, 8'h40);
        push(2'b01, 1'b0, 1'b0, 1'b1, TO + 1, -1);
        wait_cs(10);
        @(posedge clk);
        #1 force_low = 1'b1;
        wait_done(0, 40);
        force_low = 1'b0;
        @(negedge clk);

        // T5: reset in WAIT_DONE drops the op, then a fresh op completes
        issue(0, 8'h77, 8'h01);
        wait_cs(10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("t5_rst");
        rst = 1'b0;
        req = 2'b00;
        repeat (6) @(negedge clk);
        issue(0, 8'h11, 8'h22);
        push(2'b01, 1'b0, 1'b0, 1'b0, 4, -1);
        wait_done(0, 20);
        @(negedge clk);

        // T6: comparator busy at grant; select waits for ready
        force_low = 1'b1;
        issue(1, 8'h9A, 8'h9A);
        push(2'b10, 1'b0, 1'b1, 1'b0, 4, -1);
        repeat (4) @(negedge clk);
        chk("t6_gnt", int'(gnt), 2);
        force_low = 1'b0;
        wait_done(1, 20);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
